// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline: control bundle layout, forwarding selects, condition codes.
package arm_pipe_pkg;

  // Decoded control bundle; first member is the MSB of the packed word.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic       branch;
    logic       pcs;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Operand source chosen by the forwarding network.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // "Always" condition, used as the idle condition field.
  localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/id_ex_pipe_fwd_mux.sv
// Forwarding select and mux for a single execute operand.
module fwd_mux
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic [AW-1:0] ra_e,
  input  logic [DW-1:0] rd_e,
  input  logic          regwrite_m,
  input  logic [AW-1:0] wa3_m,
  input  logic [DW-1:0] aluresult_m,
  input  logic          regwrite_w,
  input  logic [AW-1:0] wa3_w,
  input  logic [DW-1:0] result_w,
  output logic [DW-1:0] src_e
);

  fwd_sel_e sel;
  logic     is_pc;

  assign is_pc = (ra_e == AW'(15));

  // Pick the youngest in-flight producer; the PC register is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (!is_pc) begin
      if (regwrite_m && (wa3_m == ra_e)) begin
        sel = FWD_M;
      end else if (regwrite_w && (wa3_w == ra_e)) begin
        sel = FWD_W;
      end
    end
  end

  // Operand mux driven by the select.
  always_comb begin
    src_e = rd_e;
    case (sel)
      FWD_M:   src_e = aluresult_m;
      FWD_W:   src_e = result_w;
      default: src_e = rd_e;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe.sv
// Decode/execute pipeline boundary: ID/EX register, operand forwarding and hazard control.
module id_ex_pipe
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_d,
  input  logic [AW-1:0] ra1_d,
  input  logic [AW-1:0] ra2_d,
  input  logic [AW-1:0] wa3_d,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [DW-1:0] imm_d,
  input  logic [CW-1:0] ctrl_d,
  input  logic [3:0]    cond_d,
  input  logic          branch_taken_e,
  input  logic          regwrite_m,
  input  logic [AW-1:0] wa3_m,
  input  logic [DW-1:0] aluresult_m,
  input  logic          regwrite_w,
  input  logic [AW-1:0] wa3_w,
  input  logic [DW-1:0] result_w,
  output logic          valid_e,
  output logic [DW-1:0] srca_e,
  output logic [DW-1:0] writedata_e,
  output logic [DW-1:0] srcb_e,
  output logic [AW-1:0] wa3_e,
  output logic [CW-1:0] ctrl_e,
  output logic [3:0]    cond_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d
);

  ctrl_t         ctrl_dt;
  ctrl_t         ctrl_q;
  logic [AW-1:0] ra1_e;
  logic [AW-1:0] ra2_e;
  logic [DW-1:0] rd1_e;
  logic [DW-1:0] rd2_e;
  logic [DW-1:0] imm_e;
  logic          ldrstall;
  logic          flush_e;

  assign ctrl_dt = ctrl_t'(ctrl_d);

  // A load in E whose destination feeds the instruction in D costs one bubble.
  assign ldrstall = valid_e & ctrl_q.memtoreg & ctrl_q.regwrite & valid_d &
                    ((wa3_e == ra1_d) | (wa3_e == ra2_d));
  assign flush_e  = ldrstall | branch_taken_e;

  // Front-end hold/clear; on a coincident branch the redirect makes the stall harmless.
  assign stall_f  = ldrstall;
  assign stall_d  = ldrstall;
  assign flush_d  = branch_taken_e;

  // ID/EX register; a bubble only clears valid/control, data fields keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e <= 1'b0;
      ctrl_q  <= '0;
      wa3_e   <= '0;
      cond_e  <= COND_AL;
      ra1_e   <= '0;
      ra2_e   <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
    end else if (flush_e) begin
      valid_e <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_e <= valid_d;
      ctrl_q  <= valid_d ? ctrl_dt : '0;
      wa3_e   <= wa3_d;
      cond_e  <= cond_d;
      ra1_e   <= ra1_d;
      ra2_e   <= ra2_d;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
      imm_e   <= imm_d;
    end
  end

  assign ctrl_e = CW'(ctrl_q);

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .ra_e        (ra1_e),
    .rd_e        (rd1_e),
    .regwrite_m  (regwrite_m),
    .wa3_m       (wa3_m),
    .aluresult_m (aluresult_m),
    .regwrite_w  (regwrite_w),
    .wa3_w       (wa3_w),
    .result_w    (result_w),
    .src_e       (srca_e)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .ra_e        (ra2_e),
    .rd_e        (rd2_e),
    .regwrite_m  (regwrite_m),
    .wa3_m       (wa3_m),
    .aluresult_m (aluresult_m),
    .regwrite_w  (regwrite_w),
    .wa3_w       (wa3_w),
    .result_w    (result_w),
    .src_e       (writedata_e)
  );

  // ALU B operand: immediate or forwarded register.
  assign srcb_e = ctrl_q.alusrc ? imm_e : writedata_e;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomized bench for id_ex_pipe against a transaction-level model of the E slot.
module tb_id_ex_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_d;
  logic [3:0]  ra1_d, ra2_d, wa3_d;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [9:0]  ctrl_d;
  logic [3:0]  cond_d;
  logic        branch_taken_e;
  logic        regwrite_m;
  logic [3:0]  wa3_m;
  logic [31:0] aluresult_m;
  logic        regwrite_w;
  logic [3:0]  wa3_w;
  logic [31:0] result_w;
  logic        valid_e;
  logic [31:0] srca_e, writedata_e, srcb_e;
  logic [3:0]  wa3_e;
  logic [9:0]  ctrl_e;
  logic [3:0]  cond_e;
  logic        stall_f, stall_d, flush_d;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] CTRL_ALU = 10'b10_0000_0000;
  localparam logic [9:0] CTRL_LDR = 10'b11_0100_0000;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .ctrl_d(ctrl_d), .cond_d(cond_d), .branch_taken_e(branch_taken_e),
    .regwrite_m(regwrite_m), .wa3_m(wa3_m), .aluresult_m(aluresult_m),
    .regwrite_w(regwrite_w), .wa3_w(wa3_w), .result_w(result_w),
    .valid_e(valid_e), .srca_e(srca_e), .writedata_e(writedata_e),
    .srcb_e(srcb_e), .wa3_e(wa3_e), .ctrl_e(ctrl_e), .cond_e(cond_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction occupying the execute slot.
  typedef struct {
    bit          valid;
    logic [9:0]  ctrl;
    logic [3:0]  wa3, cond, ra1, ra2;
    logic [31:0] rd1, rd2, imm;
  } slot_t;

  slot_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m.valid = 0; m.ctrl = '0; m.wa3 = '0; m.cond = 4'hE;
    m.ra1 = '0; m.ra2 = '0; m.rd1 = '0; m.rd2 = '0; m.imm = '0;
  endfunction

  // Load in E (regwrite+memtoreg) feeding a source of the valid instruction in D.
  function automatic bit model_ldrstall();
    return m.valid && m.ctrl[9] && m.ctrl[8] && valid_d &&
           (m.wa3 == ra1_d || m.wa3 == ra2_d);
  endfunction

  // Youngest matching producer wins, PC reads always use the decode value.
  function automatic logic [31:0] model_fwd(input logic [3:0] ra, input logic [31:0] rd);
    if (ra == 4'd15) return rd;
    if (regwrite_m && wa3_m == ra) return aluresult_m;
    if (regwrite_w && wa3_w == ra) return result_w;
    return rd;
  endfunction

  function automatic void model_clk();
    if (model_ldrstall() || branch_taken_e) begin
      m.valid = 0;
      m.ctrl  = '0;
    end else begin
      m.valid = valid_d;
      m.ctrl  = valid_d ? ctrl_d : 10'd0;
      m.wa3 = wa3_d; m.cond = cond_d; m.ra1 = ra1_d; m.ra2 = ra2_d;
      m.rd1 = rd1_d; m.rd2 = rd2_d; m.imm = imm_d;
    end
  endfunction

  task automatic check_all();
    logic [31:0] b;
    bit ld;
    ld = model_ldrstall();
    b  = model_fwd(m.ra2, m.rd2);
    check("stall_f", 32'(stall_f), 32'(ld));
    check("stall_d", 32'(stall_d), 32'(ld));
    check("flush_d", 32'(flush_d), 32'(branch_taken_e));
    check("valid_e", 32'(valid_e), 32'(m.valid));
    check("ctrl_e", 32'(ctrl_e), 32'(m.ctrl));
    check("wa3_e", 32'(wa3_e), 32'(m.wa3));
    check("cond_e", 32'(cond_e), 32'(m.cond));
    check("srca_e", srca_e, model_fwd(m.ra1, m.rd1));
    check("writedata_e", writedata_e, b);
    check("srcb_e", srcb_e, m.ctrl[6] ? m.imm : b);
  endtask

  // Called at a negedge with inputs driven; checks, clocks the model, returns at next negedge.
  task automatic tick();
    #2 check_all();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    valid_d = 0; ra1_d = 0; ra2_d = 0; wa3_d = 0;
    rd1_d = 0; rd2_d = 0; imm_d = 0; ctrl_d = 0; cond_d = 4'hE;
    branch_taken_e = 0;
    regwrite_m = 0; wa3_m = 0; aluresult_m = 0;
    regwrite_w = 0; wa3_w = 0; result_w = 0;
  endtask

  function automatic logic [3:0] pick_reg();
    case ($urandom_range(0, 7))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd3;
      3: return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic drive_rand();
    logic [9:0] c;
    c = 10'($urandom);
    if ($urandom_range(0, 2) == 0) c[9:8] = 2'b11;
    valid_d = ($urandom_range(0, 7) != 0);
    ra1_d = pick_reg(); ra2_d = pick_reg(); wa3_d = pick_reg();
    rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
    ctrl_d = c; cond_d = 4'($urandom);
    branch_taken_e = ($urandom_range(0, 7) == 0);
    regwrite_m = 1'($urandom); wa3_m = pick_reg(); aluresult_m = $urandom;
    regwrite_w = 1'($urandom); wa3_w = pick_reg(); result_w = $urandom;
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_valid_e", 32'(valid_e), 32'd0);
    check("rst_ctrl_e", 32'(ctrl_e), 32'd0);
    check("rst_cond_e", 32'(cond_e), 32'hE);
    check("rst_srca_e", srca_e, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // ALU-ALU: M result forwarded onto operand A.
    drive_idle(); tick();
    valid_d = 1; ra1_d = 4'd1; rd1_d = 32'h5; wa3_d = 4'd4; ctrl_d = CTRL_ALU;
    tick();
    drive_idle(); regwrite_m = 1; wa3_m = 4'd1; aluresult_m = 32'h10;
    #1 check("alu_alu_fwd", srca_e, 32'h10);
    tick();

    // M has priority over W, W used once M drops out.
    drive_idle(); tick();
    valid_d = 1; ra2_d = 4'd2; rd2_d = 32'h7; wa3_d = 4'd5; ctrl_d = CTRL_ALU;
    tick();
    drive_idle();
    regwrite_m = 1; wa3_m = 4'd2; aluresult_m = 32'hAA;
    regwrite_w = 1; wa3_w = 4'd2; result_w = 32'hBB;
    #1 check("mw_prio_m", writedata_e, 32'hAA);
    regwrite_m = 0;
    #1 check("mw_prio_w", writedata_e, 32'hBB);
    tick();

    // Load-use: one stall cycle, one bubble, then forward from W.
    drive_idle(); tick();
    valid_d = 1; wa3_d = 4'd3; ctrl_d = CTRL_LDR; imm_d = 32'h4;
    tick();
    drive_idle(); valid_d = 1; ra1_d = 4'd3; rd1_d = 32'h1; wa3_d = 4'd6; ctrl_d = CTRL_ALU;
    #1 check("ld_stall_f", 32'(stall_f), 32'd1);
    check("ld_stall_d", 32'(stall_d), 32'd1);
    tick();
    regwrite_m = 1; wa3_m = 4'd3; aluresult_m = 32'hDEAD;
    #1 check("ld_bubble_valid", 32'(valid_e), 32'd0);
    check("ld_stall_clear", 32'(stall_f), 32'd0);
    tick();
    regwrite_m = 0; regwrite_w = 1; wa3_w = 4'd3; result_w = 32'hCAFE;
    valid_d = 0;
    #1 check("ld_enter_valid", 32'(valid_e), 32'd1);
    check("ld_fwd_w", srca_e, 32'hCAFE);
    tick();

    // Branch coincident with load-use: flush wins, stalls still raised.
    drive_idle(); tick();
    valid_d = 1; wa3_d = 4'd3; ctrl_d = CTRL_LDR;
    tick();
    drive_idle(); valid_d = 1; ra2_d = 4'd3; wa3_d = 4'd7; ctrl_d = CTRL_ALU;
    branch_taken_e = 1;
    #1 check("br_flush_d", 32'(flush_d), 32'd1);
    check("br_stall_f", 32'(stall_f), 32'd1);
    tick();
    drive_idle();
    #1 check("br_valid_e", 32'(valid_e), 32'd0);
    check("br_ctrl_e", 32'(ctrl_e), 32'd0);
    tick();

    // r15 is never forwarded.
    valid_d = 1; ra1_d = 4'd15; rd1_d = 32'h108; wa3_d = 4'd8; ctrl_d = CTRL_ALU;
    tick();
    drive_idle();
    regwrite_m = 1; wa3_m = 4'd15; aluresult_m = 32'h1234;
    regwrite_w = 1; wa3_w = 4'd15; result_w = 32'h5555;
    #1 check("r15_guard", srca_e, 32'h108);
    tick();

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      if (i == 200) begin
        valid_d = 1;
        #3 rst_n = 0;
        #1 model_reset();
        check("midrst_valid_e", 32'(valid_e), 32'd0);
        check("midrst_ctrl_e", 32'(ctrl_e), 32'd0);
        check("midrst_cond_e", 32'(cond_e), 32'hE);
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute boundary of the pipelined ARM core, directly downstream of the register file.
- Registers the register-file read data, extended immediate and decoded control into the execute stage.
- Forwards in-flight results from memory and writeback onto the execute operands.
- Generates load-use stalls and branch/stall flushes for the front end.

Parameters:
- DW, 32, datapath width
- AW, 4, register address width (r0-r15)
- CW, 10, packed control bundle width; bit map defined in shared package

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_d  in  1  decode slot holds a real instruction
- ra1_d, ra2_d  in  AW  source register addresses, same values driven to regfile
- wa3_d  in  AW  destination register
- rd1_d, rd2_d  in  DW  regfile read data; r15 already substituted as PC+8
- imm_d  in  DW  extended immediate
- ctrl_d  in  CW  regwrite, memtoreg, memwrite, alusrc, alucontrol[1:0], flagwrite[1:0], branch, pcs
- cond_d  in  4  condition field
- branch_taken_e  in  1  PCSrc resolved in execute
- regwrite_m, wa3_m, aluresult_m  in  1/AW/DW  memory-stage writeback info
- regwrite_w, wa3_w, result_w  in  1/AW/DW  writeback-stage info
- valid_e  out  1  execute slot valid
- srca_e, writedata_e  out  DW  forwarded operands
- srcb_e  out  DW  alusrc ? imm_e : writedata_e
- wa3_e  out  AW  registered destination
- ctrl_e  out  CW  registered control, zeroed when bubble
- cond_e  out  4  registered condition field
- stall_f, stall_d  out  1  hold fetch PC and IF/ID register
- flush_d  out  1  clear IF/ID register

Behaviour:
- Reset (async, rst_n low): valid_e=0, ctrl_e=0, wa3_e=0, cond_e=4'hE, all data registers 0. Outputs are combinationally 0 except forwarding muxes, which track their inputs.
- Pipeline register (posedge clk):
  - If flush_e: valid_e<=0, ctrl_e<=0. Data fields are don't-care and hold their previous value.
  - Else: capture all _d fields; valid_e<=valid_d. Control is gated with valid_d.
- flush_e is internal: ldrstall | branch_taken_e.
- Load-use detection (combinational): ldrstall = valid_e & ctrl_e.memtoreg & ctrl_e.regwrite & valid_d & (wa3_e==ra1_d | wa3_e==ra2_d).
  - stall_f = stall_d = ldrstall.
  - Exactly one bubble is inserted; the stalled instruction enters E on the next edge with forwarding from W.
- flush_d = branch_taken_e.
  - If ldrstall and branch_taken_e coincide, the flush wins: E is bubbled and stall outputs are still asserted.
  - This is harmless because the front end redirects and flush_d clears D.
- Forwarding, independently for operand A (ra1_e) and operand B (ra2_e):
  - select aluresult_m if regwrite_m & wa3_m==ra_e & ra_e!=15;
  - else result_w if regwrite_w & wa3_w==ra_e & ra_e!=15;
  - else the registered rd.
  - Memory has priority over writeback.
  - r15 is never forwarded; the registered PC+8 is used.
- Regfile writes on negedge, so a writeback-to-decode hazard needs no extra path; the registered rd is already fresh.
- ra1_e/ra2_e are registered internally for forwarding comparison.
- All comparisons are full AW-bit equality; there is no partial decode.

Decomposition:
- Package arm_pipe_pkg holds:
  - ctrl_t packed struct of ctrl fields and CW;
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - COND_AL constant 4'hE.
- One sub-module fwd_mux (forward select + mux for one operand), instantiated twice.
- Hazard logic stays inline.

Test Plan:
- Reset mid-stream: with valid_d=1, drop rst_n mid-cycle -> valid_e, ctrl_e=0 immediately and cond_e=4'hE. No capture until rst_n rises and the next posedge occurs.
- ALU-ALU hazard: ADD r1 (regwrite_m=1, wa3_m=1, aluresult_m=0x0000_0010) with E reading ra1_e=1, rd1=0x5 -> srca_e=0x10.
- M/W priority: wa3_m=wa3_w=2, aluresult_m=0xAA, result_w=0xBB, ra2_e=2 -> writedata_e=0xAA. Then regwrite_m=0 -> writedata_e=0xBB.
- Load-use: LDR r3 in E (memtoreg, regwrite), ra1_d=3 -> stall_f=stall_d=1 for exactly one cycle and the next valid_e=0. The following cycle the instruction enters E and srca_e takes result_w when wa3_w=3.
- Branch flush with simultaneous load-use: branch_taken_e=1 and ldrstall=1 -> flush_d=1, next valid_e=0, ctrl_e=0.
- r15 guard: ra1_e=15, regwrite_m=1, wa3_m=15, aluresult_m=0x1234, rd1=0x108 -> srca_e=0x108.
